// File: rtl/multi_dice.sv
// Multi-die roller: free LFSR + counter feed each die, and the update interval stretches until the roll settles.
// Optional MULTI_DICE_SUM_EN builds a registered SUM of all die values; otherwise SUM is tied to 0.
module multi_dice #(
    parameter int          NDICE   = 2,
    parameter int          SIDES   = 6,
    parameter int          DIV_END = 160,
    parameter logic [15:0] SEED    = 16'h00DA
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               ROLL,
    input  logic [NDICE-1:0]   HOLD,
    output logic [8*NDICE-1:0] LEDS,
    output logic               BUSY,
    output logic               DONE,
    output logic [5:0]         SUM
);
    localparam int W = $clog2(SIDES);

    typedef enum logic {IDLE, ROLLING} state_t;

    state_t      state_reg, state_next;
    logic [7:0]  counter_reg, counter_next;
    logic [7:0]  clkdiv_reg, clkdiv_next;
    logic        done_reg, done_next;
    logic        load;
    logic [15:0] lfsr_reg, lfsr_next;
    logic [15:0] rc_reg;
    logic [3:0]  val_reg  [NDICE];
    logic [3:0]  val_next [NDICE];

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        logic [6:0] s;
        s = 7'b0000000;
        case (v)
            4'd0: s = 7'b0111111;
            4'd1: s = 7'b0000110;
            4'd2: s = 7'b1011011;
            4'd3: s = 7'b1001111;
            4'd4: s = 7'b1100110;
            4'd5: s = 7'b1101101;
            4'd6: s = 7'b1111101;
            4'd7: s = 7'b0000111;
            4'd8: s = 7'b1111111;
            4'd9: s = 7'b1101111;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    // Galois form of x^16+x^14+x^13+x^11+1; a nonzero seed can never reach zero.
    assign lfsr_next = {1'b0, lfsr_reg[15:1]} ^ (lfsr_reg[0] ? 16'hB400 : 16'h0000);

    always_comb begin
        state_next   = state_reg;
        counter_next = counter_reg;
        clkdiv_next  = clkdiv_reg;
        done_next    = 1'b0;
        load         = 1'b0;
        if (ROLL) begin
            state_next   = ROLLING;
            counter_next = 8'd0;
            clkdiv_next  = 8'd2;
        end else if (state_reg == ROLLING) begin
            if (counter_reg == clkdiv_reg) begin
                counter_next = 8'd0;
                clkdiv_next  = clkdiv_reg + 8'd1;
                load         = 1'b1;
                if (clkdiv_reg + 8'd1 == 8'(DIV_END)) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end else begin
                counter_next = counter_reg + 8'd1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg   <= IDLE;
            counter_reg <= 8'd0;
            clkdiv_reg  <= 8'(DIV_END);
            done_reg    <= 1'b0;
            lfsr_reg    <= SEED;
            rc_reg      <= 16'd0;
        end else begin
            state_reg   <= state_next;
            counter_reg <= counter_next;
            clkdiv_reg  <= clkdiv_next;
            done_reg    <= done_next;
            lfsr_reg    <= lfsr_next;
            rc_reg      <= rc_reg + 16'd1;
        end
    end

    assign BUSY = (state_reg == ROLLING);
    assign DONE = done_reg;

    generate
        for (genvar gi = 0; gi < NDICE; gi++) begin : g_die
            localparam int SH = (3 * gi) % 16;
            logic [15:0]  rot;
            logic [W-1:0] raw;
            logic [3:0]   raw4;
            logic [3:0]   new_val;

            assign rot     = (lfsr_reg >> SH) | (lfsr_reg << ((16 - SH) % 16));
            assign raw     = W'(rot + rc_reg);
            assign raw4    = 4'(raw);
            // raw < 2*SIDES, so a single conditional subtract folds it into range.
            assign new_val = (raw4 >= 4'(SIDES)) ? raw4 - 4'(SIDES) + 4'd1 : raw4 + 4'd1;
            assign val_next[gi] = (load && !HOLD[gi]) ? new_val : val_reg[gi];

            always_ff @(posedge CLK) begin
                if (RST) begin
                    val_reg[gi] <= 4'd1;
                end else begin
                    val_reg[gi] <= val_next[gi];
                end
            end

            assign LEDS[8*gi +: 8] = {~BUSY, seg_decode(val_reg[gi])};
        end
    endgenerate

`ifdef MULTI_DICE_SUM_EN
    logic [5:0] sum_reg, sum_next;

    // Summed from the next values so SUM is already consistent on the DONE cycle.
    always_comb begin
        sum_next = 6'd0;
        for (int i = 0; i < NDICE; i++) begin
            sum_next = sum_next + 6'(val_next[i]);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sum_reg <= 6'(NDICE);
        end else begin
            sum_reg <= sum_next;
        end
    end

    assign SUM = sum_reg;
`else
    assign SUM = 6'd0;
`endif

endmodule

// File: tb/tb_multi_dice.sv
// Randomized bench for multi_dice: a schedule-based model predicts LEDS/BUSY/DONE/SUM every cycle.
// A second small instance (SIDES=9, DIV_END=3) checks value range and coverage over many short rolls.
module tb_multi_dice;
    localparam int          NDICE   = 2;
    localparam int          SIDES   = 6;
    localparam int          DIV_END = 160;
    localparam logic [15:0] SEED    = 16'h00DA;
    localparam int          W       = $clog2(SIDES);

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        roll = 1'b0;
    logic [1:0]  hold = 2'b00;
    logic [15:0] leds;
    logic        busy, done;
    logic [5:0]  sum;

    logic        roll9 = 1'b0;
    logic [0:0]  hold9 = 1'b0;
    logic [7:0]  leds9;
    logic        busy9, done9;
    logic [5:0]  sum9;

    always #5 clk = ~clk;

    multi_dice #(.NDICE(NDICE), .SIDES(SIDES), .DIV_END(DIV_END), .SEED(SEED)) dut (
        .CLK(clk), .RST(rst), .ROLL(roll), .HOLD(hold),
        .LEDS(leds), .BUSY(busy), .DONE(done), .SUM(sum)
    );

    multi_dice #(.NDICE(1), .SIDES(9), .DIV_END(3), .SEED(SEED)) dut9 (
        .CLK(clk), .RST(rst), .ROLL(roll9), .HOLD(hold9),
        .LEDS(leds9), .BUSY(busy9), .DONE(done9), .SUM(sum9)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: update instants are precomputed as offsets from the roll edge.
    bit          upd [0:16383];
    int          total;
    logic [15:0] m_lfsr, m_rc;
    bit          m_busy, m_done;
    int          m_t;
    int          m_val [2];
    logic [6:0]  seg_tab [10];
    bit [9:0]    seen9;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        logic [15:0] n;
        n = l >> 1;
        if (l[0]) begin
            n[15] = n[15] ^ 1'b1;
            n[13] = n[13] ^ 1'b1;
            n[12] = n[12] ^ 1'b1;
            n[10] = n[10] ^ 1'b1;
        end
        return n;
    endfunction

    function automatic int die_value(input int i, input logic [15:0] l, input logic [15:0] r);
        logic [15:0] rot;
        int          rnd;
        for (int j = 0; j < 16; j++) rot[j] = l[(j + 3 * i) % 16];
        rnd = (int'(rot) + int'(r)) % 65536;
        return (rnd % (1 << W)) % SIDES + 1;
    endfunction

    task automatic model_step();
        logic [15:0] l0;
        logic [15:0] r0;
        bit          nd;
        l0 = m_lfsr;
        r0 = m_rc;
        nd = 1'b0;
        if (rst) begin
            m_lfsr = SEED; m_rc = 16'd0; m_busy = 1'b0; m_t = 0; m_done = 1'b0;
            m_val[0] = 1; m_val[1] = 1;
        end else begin
            if (roll) begin
                m_busy = 1'b1;
                m_t    = 0;
            end else if (m_busy) begin
                m_t++;
                if (upd[m_t]) begin
                    for (int i = 0; i < NDICE; i++)
                        if (!hold[i]) m_val[i] = die_value(i, l0, r0);
                end
                if (m_t == total) begin
                    m_busy = 1'b0;
                    nd     = 1'b1;
                end
            end
            m_done = nd;
            m_lfsr = lfsr_step(l0);
            m_rc   = r0 + 16'd1;
        end
    endtask

    // One clock: model advances on the edge, outputs compared half a cycle later.
    task automatic tick();
        logic [15:0] exp_leds;
        int          exp_sum;
        int          v9;
        roll9 = ($urandom_range(0, 3) == 0);
        @(posedge clk);
        model_step();
        @(negedge clk);
        exp_leds = {~m_busy, seg_tab[m_val[1]], ~m_busy, seg_tab[m_val[0]]};
`ifdef MULTI_DICE_SUM_EN
        exp_sum = m_val[0] + m_val[1];
`else
        exp_sum = 0;
`endif
        check("leds", 32'(leds), 32'(exp_leds));
        check("busy", 32'(busy), 32'(m_busy));
        check("done", 32'(done), 32'(m_done));
        check("sum",  32'(sum),  32'(exp_sum));
        v9 = 0;
        for (int v = 1; v <= 9; v++) if (leds9[6:0] == seg_tab[v]) v9 = v;
        check("die9_range", 32'(v9 >= 1 && v9 <= 9), 32'd1);
        seen9[v9] = 1'b1;
    endtask

    initial begin
        int t, k, ch0, ch1, early, dones;
        logic [15:0] l;
        logic [7:0]  d0, d1;

        seg_tab[0] = 7'b0111111; seg_tab[1] = 7'b0000110; seg_tab[2] = 7'b1011011;
        seg_tab[3] = 7'b1001111; seg_tab[4] = 7'b1100110; seg_tab[5] = 7'b1101101;
        seg_tab[6] = 7'b1111101; seg_tab[7] = 7'b0000111; seg_tab[8] = 7'b1111111;
        seg_tab[9] = 7'b1101111;
        seen9 = '0;
        for (int i = 0; i < 16384; i++) upd[i] = 1'b0;
        t = 0;
        for (k = 2; k < DIV_END; k++) begin
            t = t + k + 1;
            upd[t] = 1'b1;
        end
        total = t;

        // Hand-derived pins for the model itself.
        check("model_total", 32'(total), 32'd12877);
        l = lfsr_step(lfsr_step(lfsr_step(SEED)));
        check("model_lfsr3", 32'(l), 32'h5A1B);

        // Reset
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_leds", 32'(leds), 32'h8686);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
`ifdef MULTI_DICE_SUM_EN
        check("rst_sum", 32'(sum), 32'd2);
`else
        check("rst_sum", 32'(sum), 32'd0);
`endif

        // Single roll pulse, no hold
        hold = 2'b00;
        roll = 1'b1; tick(); roll = 1'b0;
        t = 0;
        while (!done && t < 13500) begin tick(); t++; end
        check("roll_len", 32'(t), 32'd12877);
        check("roll_dp", 32'(leds[7] & leds[15]), 32'd1);

        // Die 1 held for the whole roll
        hold = 2'b10;
        roll = 1'b1; tick(); roll = 1'b0;
        d0 = leds[7:0]; d1 = leds[15:8];
        ch0 = 0; ch1 = 0; t = 0;
        while (!done && t < 13500) begin
            tick(); t++;
            if (leds[6:0] != d0[6:0]) ch0++;
            if (leds[14:8] != d1[6:0]) ch1++;
            d0 = leds[7:0]; d1 = leds[15:8];
        end
        check("hold_len", 32'(t), 32'd12877);
        check("hold_die1_static", 32'(ch1), 32'd0);
        check("hold_die0_moves", 32'(ch0 > 0), 32'd1);
        hold = 2'b00;

        // Re-pulse at cycle 5000
        roll = 1'b1; tick(); roll = 1'b0;
        early = 0;
        for (int i = 1; i < 5000; i++) begin tick(); if (done) early++; end
        roll = 1'b1; tick(); roll = 1'b0;
        t = 0;
        while (!done && t < 13500) begin tick(); t++; end
        check("repulse_early_done", 32'(early), 32'd0);
        check("repulse_len", 32'(t), 32'd12877);

        // Reset at cycle 100 of a roll
        roll = 1'b1; tick(); roll = 1'b0;
        for (int i = 1; i < 100; i++) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        check("midrst_leds", 32'(leds), 32'h8686);
        check("midrst_busy", 32'(busy), 32'd0);
        dones = 0;
        for (int i = 0; i < 300; i++) begin tick(); if (done) dones++; end
        check("midrst_no_done", 32'(dones), 32'd0);

        // Random ROLL pulses and HOLD changes
        for (int i = 0; i < 4000; i++) begin
            roll = ($urandom_range(0, 299) == 0);
            hold = 2'($urandom);
            tick();
        end

        // ROLL held continuously
        roll = 1'b1;
        dones = 0;
        for (int i = 0; i < 100; i++) begin tick(); if (done) dones++; end
        check("rollheld_busy", 32'(busy), 32'd1);
        check("rollheld_no_done", 32'(dones), 32'd0);
        roll = 1'b0;

        // Final roll with HOLD randomized every cycle
        t = 0;
        while (!done && t < 13500) begin
            hold = 2'($urandom);
            tick(); t++;
        end
        check("randhold_len", 32'(t), 32'd12877);

        check("die9_all_seen", 32'(seen9[9:1]), 32'h1FF);
        check("die9_none_zero", 32'(seen9[0]), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
